// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_pkg -- shared constants and clear-FSM encoding for the RAM
// Rev    : 1.0
// ============================================================================
package ram_pkg;

  // Read-during-write modes for the WRITE_FIRST parameter
  localparam int RD_OLD = 0;
  localparam int RD_NEW = 1;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_read_pipe.sv
`default_nettype none
// ============================================================================
// Module : ram_read_pipe -- per-port q/valid register stage(s), 1 or 2 deep
// Rev    : 1.0
// ============================================================================
module ram_read_pipe
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  valid
);

  generate
    if (RD_LATENCY == RD_LATENCY_MIN) begin : g_lat1
      logic [DATA_WIDTH-1:0] q_q, q_d;
      logic                  valid_q, valid_d;

      always_comb begin
        q_d     = q_q;
        valid_d = rd_en;
        if (rd_en) q_d = rd_data;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_q     <= '0;
          valid_q <= 1'b0;
        end else begin
          q_q     <= q_d;
          valid_q <= valid_d;
        end
      end

      assign q     = q_q;
      assign valid = valid_q;
    end else if (RD_LATENCY == RD_LATENCY_MAX) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d, q_q, q_d;
      logic                  s1_valid_q, s1_valid_d, valid_q, valid_d;

      // Both stages hold their data when idle, so q keeps its last value
      always_comb begin
        s1_valid_d = rd_en;
        s1_data_d  = rd_en ? rd_data : s1_data_q;
        valid_d    = s1_valid_q;
        q_d        = s1_valid_q ? s1_data_q : q_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_data_q  <= '0;
          s1_valid_q <= 1'b0;
          q_q        <= '0;
          valid_q    <= 1'b0;
        end else begin
          s1_data_q  <= s1_data_d;
          s1_valid_q <= s1_valid_d;
          q_q        <= q_d;
          valid_q    <= valid_d;
        end
      end

      assign q     = q_q;
      assign valid = valid_q;
    end else begin : g_bad_latency
      $error("ram_read_pipe: RD_LATENCY must be 1 or 2");
      assign q     = '0;
      assign valid = 1'b0;
    end
  endgenerate

endmodule : ram_read_pipe
`default_nettype wire

// File: rtl/ram_dual_port_gen2.sv
`default_nettype none
// ============================================================================
// Module : ram_dual_port_gen2 -- single-clock true dual-port RAM with
//          configurable read latency / read-during-write and collision flag.
//          Define RAM_CLEAR_EN for the post-reset memory clear.
// Rev    : 1.0
// ============================================================================
module ram_dual_port_gen2
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int RD_LATENCY    = 1,
  parameter int WRITE_FIRST   = RD_OLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enA,
  input  logic                     weA,
  input  logic [ADDRESS_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0]    dataA,
  output logic [DATA_WIDTH-1:0]    qA,
  output logic                     validA,
  input  logic                     enB,
  input  logic                     weB,
  input  logic [ADDRESS_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0]    dataB,
  output logic [DATA_WIDTH-1:0]    qB,
  output logic                     validB,
  output logic                     collision,
  output logic                     init_busy
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     ports_ready;
  logic                     clr_we;
  logic [ADDRESS_WIDTH-1:0] clr_addr;

`ifdef RAM_CLEAR_EN
  clr_state_t               state_q;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q;
  logic                     init_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY: state_q <= READY;
      endcase
    end
  end

  assign ports_ready = (state_q == READY);
  assign clr_we      = (state_q == CLEAR);
  assign clr_addr    = clr_cnt_q;
  assign init_busy   = init_busy_q;
`else
  assign ports_ready = 1'b1;
  assign clr_we      = 1'b0;
  assign clr_addr    = '0;
  assign init_busy   = 1'b0;
`endif

  logic                  same_addr;
  logic                  wr_a, wr_b, rd_a, rd_b;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
  logic                  collision_d, collision_q;

  always_comb begin
    same_addr = (addrA == addrB);
    wr_a      = ports_ready & enA & weA;
    rd_a      = ports_ready & enA & ~weA;
    rd_b      = ports_ready & enB & ~weB;
    // Port A wins a same-address write race; B's write is dropped
    wr_b      = ports_ready & enB & weB & ~(wr_a & same_addr);

    rd_data_a = mem[addrA];
    rd_data_b = mem[addrB];
    if (WRITE_FIRST == RD_NEW) begin
      if (wr_b && same_addr) rd_data_a = dataB;
      if (wr_a && same_addr) rd_data_b = dataA;
    end

    collision_d = ports_ready & enA & enB & same_addr & (weA | weB);
  end

  // Array is deliberately not reset; rst only blocks writes while asserted
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) mem[clr_addr] <= '0;
      if (wr_a)   mem[addrA]    <= dataA;
      if (wr_b)   mem[addrB]    <= dataB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= collision_d;
  end

  assign collision = collision_q;

  ram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_a),
    .rd_data (rd_data_a),
    .q       (qA),
    .valid   (validA)
  );

  ram_read_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_b),
    .rd_data (rd_data_b),
    .q       (qB),
    .valid   (validB)
  );

endmodule : ram_dual_port_gen2
`default_nettype wire

// File: tb/tb_ram_dual_port_gen2.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_dual_port_gen2 -- directed + random checks of the dual-port
//          RAM against an array/scoreboard reference model.
// Rev    : 1.0
// ============================================================================
module tb_ram_dual_port_gen2;
  parameter int RD_LATENCY  = 1;
  parameter int WRITE_FIRST = 0;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_CLEAR_EN
  localparam bit HAS_CLEAR = 1'b1;
`else
  localparam bit HAS_CLEAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          enA, weA, enB, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dataA, dataB, qA, qB;
  logic          validA, validB, collision, init_busy;

  always #5 clk = ~clk;

  ram_dual_port_gen2 #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .RD_LATENCY    (RD_LATENCY),
    .WRITE_FIRST   (WRITE_FIRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enA       (enA),
    .weA       (weA),
    .addrA     (addrA),
    .dataA     (dataA),
    .qA        (qA),
    .validA    (validA),
    .enB       (enB),
    .weB       (weB),
    .addrB     (addrB),
    .dataB     (dataB),
    .qB        (qB),
    .validB    (validB),
    .collision (collision),
    .init_busy (init_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory contents plus per-port queues of reads due at a cycle
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  logic [DW-1:0] ref_mem [DEPTH];
  rd_t           pend_a[$];
  rd_t           pend_b[$];
  int            cyc = 0;
  int            clear_left = 0;
  logic          exp_va, exp_vb, exp_coll, exp_busy;
  logic [DW-1:0] exp_qa, exp_qb;

  task automatic idle();
    enA = 1'b0; weA = 1'b0; enB = 1'b0; weB = 1'b0;
  endtask

  task automatic tick();
    logic coll;
    rd_t  e;
    coll = 1'b0;
    if (clear_left > 0) begin
      ref_mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else begin
      if (enA && !weA) begin
        e.due = cyc + RD_LATENCY - 1;
        e.d   = (WRITE_FIRST != 0 && enB && weB && addrB == addrA) ? dataB : ref_mem[addrA];
        pend_a.push_back(e);
      end
      if (enB && !weB) begin
        e.due = cyc + RD_LATENCY - 1;
        e.d   = (WRITE_FIRST != 0 && enA && weA && addrA == addrB) ? dataA : ref_mem[addrB];
        pend_b.push_back(e);
      end
      coll = enA && enB && (addrA == addrB) && (weA || weB);
      if (enB && weB) ref_mem[addrB] = dataB;
      if (enA && weA) ref_mem[addrA] = dataA;
    end
    @(posedge clk);
    #1;
    exp_coll = coll;
    exp_busy = (clear_left > 0);
    exp_va   = 1'b0;
    exp_vb   = 1'b0;
    if (pend_a.size() > 0 && pend_a[0].due == cyc) begin
      e = pend_a.pop_front(); exp_va = 1'b1; exp_qa = e.d;
    end
    if (pend_b.size() > 0 && pend_b[0].due == cyc) begin
      e = pend_b.pop_front(); exp_vb = 1'b1; exp_qb = e.d;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #1;
    pend_a.delete();
    pend_b.delete();
    exp_va = 1'b0; exp_vb = 1'b0; exp_qa = '0; exp_qb = '0;
    exp_coll = 1'b0; exp_busy = HAS_CLEAR;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_left = HAS_CLEAR ? DEPTH : 0;
  endtask

  task automatic wait_clear();
    while (clear_left > 0) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (qA !== '0)      begin n_bad++; $display("FAIL reset_qA: got %h want 00", qA); end
    n_cmp++; if (qB !== '0)      begin n_bad++; $display("FAIL reset_qB: got %h want 00", qB); end
    n_cmp++; if (validA !== 1'b0) begin n_bad++; $display("FAIL reset_validA: got %b want 0", validA); end
    n_cmp++; if (validB !== 1'b0) begin n_bad++; $display("FAIL reset_validB: got %b want 0", validB); end
    n_cmp++; if (collision !== 1'b0) begin n_bad++; $display("FAIL reset_collision: got %b want 0", collision); end
    n_cmp++; if (init_busy !== HAS_CLEAR) begin n_bad++; $display("FAIL reset_init_busy: got %b want %b", init_busy, HAS_CLEAR); end
    wait_clear();
    n_cmp++; if (init_busy !== 1'b0) begin n_bad++; $display("FAIL ready_init_busy: got %b want 0", init_busy); end
  endtask

  task automatic test_write_read();
    int            lat;
    logic [DW-1:0] got;
    idle(); enA = 1'b1; weA = 1'b1; addrA = 4'd3; dataA = 8'h5A; tick();
    n_cmp++; if (validA !== 1'b0) begin n_bad++; $display("FAIL wr_validA: got %b want 0", validA); end
    idle(); enB = 1'b1; weB = 1'b0; addrB = 4'd3;
    lat = 0; got = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      idle();
      n_cmp++; if (validB !== exp_vb) begin n_bad++; $display("FAIL wr_rd_validB k=%0d: got %b want %b", k, validB, exp_vb); end
      if (validB === 1'b1 && lat == 0) begin lat = k; got = qB; end
    end
    n_cmp++; if (lat != RD_LATENCY) begin n_bad++; $display("FAIL wr_rd_latency: got %0d want %0d", lat, RD_LATENCY); end
    n_cmp++; if (got !== 8'h5A) begin n_bad++; $display("FAIL wr_rd_data: got %h want 5a", got); end
  endtask

  task automatic test_back_to_back();
    int            run, max_run;
    logic [DW-1:0] nxt;
    for (int i = 0; i < DEPTH; i++) begin
      idle(); enA = 1'b1; weA = 1'b1; addrA = AW'(i); dataA = DW'(i); tick();
    end
    run = 0; max_run = 0; nxt = '0;
    for (int i = 0; i < DEPTH + RD_LATENCY + 1; i++) begin
      idle();
      if (i < DEPTH) begin enA = 1'b1; weA = 1'b0; addrA = AW'(i); end
      tick();
      n_cmp++; if (validA !== exp_va) begin n_bad++; $display("FAIL b2b_validA i=%0d: got %b want %b", i, validA, exp_va); end
      if (validA === 1'b1) begin
        n_cmp++; if (qA !== nxt) begin n_bad++; $display("FAIL b2b_qA: got %h want %h", qA, nxt); end
        nxt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    idle();
    n_cmp++; if (max_run != DEPTH) begin n_bad++; $display("FAIL b2b_run: got %0d want %0d", max_run, DEPTH); end
  endtask

  task automatic test_read_during_write();
    int            pulses;
    logic [DW-1:0] want, got;
    idle(); enA = 1'b1; weA = 1'b1; addrA = 4'd7; dataA = 8'h11; tick();
    idle(); enA = 1'b1; weA = 1'b1; addrA = 4'd7; dataA = 8'h22;
    enB = 1'b1; weB = 1'b0; addrB = 4'd7;
    want = (WRITE_FIRST != 0) ? 8'h22 : 8'h11;
    pulses = 0; got = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL rdw_collision k=%0d: got %b want %b", k, collision, exp_coll); end
      if (collision === 1'b1) pulses++;
      if (validB === 1'b1) got = qB;
    end
    n_cmp++; if (got !== want) begin n_bad++; $display("FAIL rdw_qB: got %h want %h", got, want); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL rdw_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_write_write();
    int            pulses;
    logic [DW-1:0] got;
    idle(); enA = 1'b1; weA = 1'b1; addrA = 4'd9; dataA = 8'hAA;
    enB = 1'b1; weB = 1'b1; addrB = 4'd9; dataB = 8'hBB;
    pulses = 0; got = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      if (collision === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ww_pulses: got %0d want 1", pulses); end
    enA = 1'b1; weA = 1'b0; addrA = 4'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      if (validA === 1'b1) got = qA;
    end
    n_cmp++; if (got !== 8'hAA) begin n_bad++; $display("FAIL ww_data: got %h want aa", got); end
    enA = 1'b1; weA = 1'b1; addrA = 4'd1; dataA = 8'h01;
    enB = 1'b1; weB = 1'b1; addrB = 4'd2; dataB = 8'h02;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      if (collision === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL ww_diff_addr_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enA = 1'($urandom_range(0, 1)); weA = 1'($urandom_range(0, 1));
      enB = 1'($urandom_range(0, 1)); weB = 1'($urandom_range(0, 1));
      addrA = AW'($urandom_range(0, DEPTH - 1));
      addrB = ($urandom_range(0, 2) == 0) ? addrA : AW'($urandom_range(0, DEPTH - 1));
      dataA = DW'($urandom); dataB = DW'($urandom);
      tick();
      n_cmp++; if (validA !== exp_va) begin n_bad++; $display("FAIL rnd_validA cyc=%0d: got %b want %b", cyc, validA, exp_va); end
      n_cmp++; if (qA !== exp_qa) begin n_bad++; $display("FAIL rnd_qA cyc=%0d: got %h want %h", cyc, qA, exp_qa); end
      n_cmp++; if (validB !== exp_vb) begin n_bad++; $display("FAIL rnd_validB cyc=%0d: got %b want %b", cyc, validB, exp_vb); end
      n_cmp++; if (qB !== exp_qb) begin n_bad++; $display("FAIL rnd_qB cyc=%0d: got %h want %h", cyc, qB, exp_qb); end
      n_cmp++; if (collision !== exp_coll) begin n_bad++; $display("FAIL rnd_collision cyc=%0d: got %b want %b", cyc, collision, exp_coll); end
    end
    idle();
    for (int i = 0; i < RD_LATENCY + 1; i++) tick();
  endtask

  task automatic test_reset_inflight();
    idle(); enA = 1'b1; weA = 1'b0; addrA = 4'd5; tick(); idle();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (qA !== '0) begin n_bad++; $display("FAIL rst_fly_qA: got %h want 00", qA); end
    n_cmp++; if (validA !== 1'b0) begin n_bad++; $display("FAIL rst_fly_validA: got %b want 0", validA); end
    do_reset();
    wait_clear();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (validA !== 1'b0) begin n_bad++; $display("FAIL rst_fly_late_valid k=%0d: got %b want 0", k, validA); end
    end
  endtask

`ifdef RAM_CLEAR_EN
  task automatic test_clear();
    int cnt, nreads;
    for (int i = 0; i < DEPTH; i++) begin
      idle(); enA = 1'b1; weA = 1'b1; addrA = AW'(i); dataA = DW'(8'hC0 + i); tick();
    end
    do_reset();
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 3 * DEPTH) begin
      idle();
      if (cnt == DEPTH - 1) begin enA = 1'b1; weA = 1'b1; addrA = 4'd0; dataA = 8'h77; end
      else if (cnt == 2) begin enB = 1'b1; weB = 1'b0; addrB = 4'd4; end
      tick();
      cnt++;
      n_cmp++; if (validB !== 1'b0) begin n_bad++; $display("FAIL clr_validB cnt=%0d: got %b want 0", cnt, validB); end
    end
    idle();
    n_cmp++; if (cnt != DEPTH) begin n_bad++; $display("FAIL clr_busy_cycles: got %0d want %0d", cnt, DEPTH); end
    nreads = 0;
    for (int i = 0; i < DEPTH + RD_LATENCY; i++) begin
      idle();
      if (i < DEPTH) begin enA = 1'b1; weA = 1'b0; addrA = AW'(i); end
      tick();
      if (validA === 1'b1) begin
        nreads++;
        n_cmp++; if (qA !== 8'h00) begin n_bad++; $display("FAIL clr_data read#%0d: got %h want 00", nreads, qA); end
      end
    end
    idle();
    n_cmp++; if (nreads != DEPTH) begin n_bad++; $display("FAIL clr_read_count: got %0d want %0d", nreads, DEPTH); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    addrA = '0; addrB = '0; dataA = '0; dataB = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_read_during_write();
    test_write_write();
    test_random();
    test_reset_inflight();
`ifdef RAM_CLEAR_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ram_dual_port_gen2
`default_nettype wire
